thermocouple_spi_master: RTL and testbench

THERMOCOUPLE_SPI_MASTER -- requirements
Module: thermocouple_spi_master

---
 rtl/thermocouple_pkg.sv | 16 +
 rtl/thermocouple_spi_master_if.sv | 11 +
 rtl/sync_2ff.sv | 26 ++
 rtl/thermocouple_spi_master.sv | 116 +++++++++++
 tb/tb_thermocouple_spi_master.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/thermocouple_pkg.sv
// Shared types and constants for the thermocouple reader's SPI front end.
package thermocouple_pkg;

  localparam int FRAME_BITS      = 32;
  localparam int CLK_DIV_DEFAULT = 4;
  localparam int BIT_CNT_W       = 6;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    RECOVER
  } state_e;

endpackage

// File: rtl/thermocouple_spi_master_if.sv
// SPI pins between the master and the thermocouple converter.
interface thermocouple_spi_master_if;

  logic sclk;
  logic cs_n;
  logic miso;

  modport master (output sclk, output cs_n, input miso);
  modport slave  (input sclk, input cs_n, output miso);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/thermocouple_spi_master.sv
// Read-only SPI master: clocks a 32-bit frame out of a thermocouple converter
// and publishes it atomically with a one-cycle valid pulse.
module thermocouple_spi_master
  import thermocouple_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spi_ena,
  output logic                        spi_not_busy,
  output logic [FRAME_BITS-1:0]       spi_rx_data,
  output logic                        rx_valid,
  thermocouple_spi_master_if.master   spi
);

  localparam int                    CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(FRAME_BITS);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic                    not_busy_q, not_busy_d;
  logic                    miso_s;
  logic                    half_done;

  sync_2ff #(.WIDTH(1)) u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d   (spi.miso),
    .q   (miso_s)
  );

  assign half_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (spi_ena)   state_d = SETUP;
      SETUP:    if (half_done) state_d = SHIFT_HI;
      SHIFT_HI: if (half_done) state_d = SHIFT_LO;
      SHIFT_LO: if (half_done) state_d = (bit_cnt_q == LAST_BIT) ? RECOVER : SHIFT_HI;
      RECOVER:  if (half_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = '0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    if (state_d == state_q && state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (state_q == IDLE && state_d == SETUP) begin
      bit_cnt_d = '0;
    end

    // Sample on the same edge that raises sclk; miso_s has settled since the last fall.
    if (state_d == SHIFT_HI && state_q != SHIFT_HI) begin
      shift_d   = {shift_q[FRAME_BITS-2:0], miso_s};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (state_q == RECOVER && state_d == IDLE) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end

    // Pin outputs are registered from the next state so they never glitch.
    sclk_d     = (state_d == SHIFT_HI);
    cs_n_d     = (state_d == IDLE) || (state_d == RECOVER);
    not_busy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      not_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      not_busy_q <= not_busy_d;
    end
  end

  assign spi.sclk     = sclk_q;
  assign spi.cs_n     = cs_n_q;
  assign spi_not_busy = not_busy_q;
  assign spi_rx_data  = rx_data_q;
  assign rx_valid     = rx_valid_q;

endmodule

// File: tb/tb_thermocouple_spi_master.sv
// Directed bench: two masters (CLK_DIV 4 and 3) each reading from a converter model.
module tb_thermocouple_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena_a = 1'b0;
  logic        ena_b = 1'b0;
  logic        nb_a, nb_b;
  logic        valid_a, valid_b;
  logic [31:0] data_a, data_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  thermocouple_spi_master_if bus_a ();
  thermocouple_spi_master_if bus_b ();

  thermocouple_spi_master #(.CLK_DIV(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .spi_ena      (ena_a),
    .spi_not_busy (nb_a),
    .spi_rx_data  (data_a),
    .rx_valid     (valid_a),
    .spi          (bus_a)
  );

  thermocouple_spi_master #(.CLK_DIV(3)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .spi_ena      (ena_b),
    .spi_not_busy (nb_b),
    .spi_rx_data  (data_b),
    .rx_valid     (valid_b),
    .spi          (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter models: first bit on cs_n fall, next bit on each sclk fall.
  logic [31:0] next_a = 32'h0, next_b = 32'h0;
  logic [31:0] cur_a = 32'h0, cur_b = 32'h0;
  int          idx_a = 31, idx_b = 31;
  bit          armed_a = 1'b0, armed_b = 1'b0;

  always @(negedge bus_a.cs_n or posedge bus_a.cs_n or negedge bus_a.sclk) begin
    if (bus_a.cs_n !== 1'b0) begin
      armed_a    <= 1'b0;
      idx_a      <= 31;
      bus_a.miso <= 1'b0;
    end else if (!armed_a) begin
      armed_a    <= 1'b1;
      cur_a      <= next_a;
      idx_a      <= 31;
      bus_a.miso <= next_a[31];
    end else if (idx_a > 0) begin
      idx_a      <= idx_a - 1;
      bus_a.miso <= cur_a[idx_a-1];
    end
  end

  always @(negedge bus_b.cs_n or posedge bus_b.cs_n or negedge bus_b.sclk) begin
    if (bus_b.cs_n !== 1'b0) begin
      armed_b    <= 1'b0;
      idx_b      <= 31;
      bus_b.miso <= 1'b0;
    end else if (!armed_b) begin
      armed_b    <= 1'b1;
      cur_b      <= next_b;
      idx_b      <= 31;
      bus_b.miso <= next_b[31];
    end else if (idx_b > 0) begin
      idx_b      <= idx_b - 1;
      bus_b.miso <= cur_b[idx_b-1];
    end
  end

  // sclk monitors: rises per cs_n window, rises seen while deselected.
  int rises_a = 0, rises_b = 0;
  int viol_a = 0, viol_b = 0;
  int win_a = 0, win_b = 0;
  int winbad_a = 0, winbad_b = 0;

  always @(posedge bus_a.sclk or negedge bus_a.cs_n) begin
    if (bus_a.cs_n === 1'b0 && bus_a.sclk === 1'b1) rises_a <= rises_a + 1;
    else if (bus_a.cs_n === 1'b0)                   rises_a <= 0;
    if (bus_a.sclk === 1'b1 && bus_a.cs_n !== 1'b0 && rst === 1'b1) viol_a <= viol_a + 1;
  end

  always @(posedge bus_b.sclk or negedge bus_b.cs_n) begin
    if (bus_b.cs_n === 1'b0 && bus_b.sclk === 1'b1) rises_b <= rises_b + 1;
    else if (bus_b.cs_n === 1'b0)                   rises_b <= 0;
    if (bus_b.sclk === 1'b1 && bus_b.cs_n !== 1'b0 && rst === 1'b1) viol_b <= viol_b + 1;
  end

  always @(posedge bus_a.cs_n) begin
    if (rst === 1'b1) begin
      win_a <= win_a + 1;
      if (rises_a != 32) winbad_a <= winbad_a + 1;
    end
  end

  always @(posedge bus_b.cs_n) begin
    if (rst === 1'b1) begin
      win_b <= win_b + 1;
      if (rises_b != 32) winbad_b <= winbad_b + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_nb(input int inst);
    return (inst == 0) ? nb_a : nb_b;
  endfunction
  function automatic logic get_valid(input int inst);
    return (inst == 0) ? valid_a : valid_b;
  endfunction
  function automatic logic [31:0] get_data(input int inst);
    return (inst == 0) ? data_a : data_b;
  endfunction
  function automatic logic get_csn(input int inst);
    return (inst == 0) ? bus_a.cs_n : bus_b.cs_n;
  endfunction
  function automatic logic get_sclk(input int inst);
    return (inst == 0) ? bus_a.sclk : bus_b.sclk;
  endfunction

  // Entered at the first busy negedge; leaves at the first not-busy negedge.
  task automatic wait_done(input int inst, input logic [31:0] exp_data,
                           input logic [31:0] prev_data, input int exp_busy,
                           input string tag, output int done_cyc);
    int busy;
    bit quiet;
    busy  = 0;
    quiet = 1'b1;
    while (get_nb(inst) == 1'b0 && busy < 2000) begin
      busy++;
      if (get_valid(inst) !== 1'b0 || get_data(inst) !== prev_data) quiet = 1'b0;
      @(negedge clk);
    end
    done_cyc = cyc;
    check_eq({tag, "_busy"}, busy, exp_busy);
    check_eq({tag, "_stable"}, {31'd0, quiet}, 32'd1);
    check_eq({tag, "_valid"}, {31'd0, get_valid(inst)}, 32'd1);
    check_eq({tag, "_data"}, get_data(inst), exp_data);
    $display("txn %s: inst %0d data 0x%08h busy %0d cycles", tag, inst, get_data(inst), busy);
  endtask

  task automatic run_single(input int inst, input logic [31:0] frame,
                            input logic [31:0] prev, input int exp_busy, input string tag);
    int done_cyc;
    if (inst == 0) next_a = frame; else next_b = frame;
    @(negedge clk);
    if (inst == 0) ena_a = 1'b1; else ena_b = 1'b1;
    @(negedge clk);
    if (inst == 0) ena_a = 1'b0; else ena_b = 1'b0;
    check_eq({tag, "_csn"}, {31'd0, get_csn(inst)}, 32'd0);
    check_eq({tag, "_setup_sclk"}, {31'd0, get_sclk(inst)}, 32'd0);
    wait_done(inst, frame, prev, exp_busy, tag, done_cyc);
    @(negedge clk);
    check_eq({tag, "_pulse"}, {31'd0, get_valid(inst)}, 32'd0);
    check_eq({tag, "_hold"}, get_data(inst), frame);
  endtask

  initial begin
    int  t_prev, t_now, waited;
    bit  reached, saw_valid, left_idle;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_csn",   {31'd0, bus_a.cs_n}, 32'd1);
    check_eq("rst_sclk",  {31'd0, bus_a.sclk}, 32'd0);
    check_eq("rst_nb",    {31'd0, nb_a}, 32'd1);
    check_eq("rst_valid", {31'd0, valid_a}, 32'd0);
    check_eq("rst_data",  data_a, 32'h0);
    check_eq("rst_data_b", data_b, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_hold", {31'd0, nb_a}, 32'd1);

    // Single frame, CLK_DIV=4
    run_single(0, 32'hA5C3_1E07, 32'h0, 264, "t1");

    // Three back-to-back frames with spi_ena held high
    next_a = 32'h0000_0001;
    ena_a  = 1'b1;
    @(negedge clk);
    check_eq("t2_start", {31'd0, nb_a}, 32'd0);
    next_a = 32'h8000_0000;
    wait_done(0, 32'h0000_0001, 32'hA5C3_1E07, 264, "t2f0", t_prev);
    @(negedge clk);
    check_eq("t2_nogap0", {31'd0, nb_a}, 32'd0);
    next_a = 32'hFFFF_FFFF;
    wait_done(0, 32'h8000_0000, 32'h0000_0001, 264, "t2f1", t_now);
    check_eq("t2_period0", t_now - t_prev, 265);
    t_prev = t_now;
    @(negedge clk);
    check_eq("t2_nogap1", {31'd0, nb_a}, 32'd0);
    wait_done(0, 32'hFFFF_FFFF, 32'h8000_0000, 264, "t2f2", t_now);
    check_eq("t2_period1", t_now - t_prev, 265);
    ena_a = 1'b0;
    @(negedge clk);
    check_eq("t2_stop_nb", {31'd0, nb_a}, 32'd1);
    check_eq("t2_stop_data", data_a, 32'hFFFF_FFFF);

    // Reset abort at bit 17, then a clean frame
    next_a = 32'h1234_5678;
    @(negedge clk);
    ena_a = 1'b1;
    @(negedge clk);
    ena_a = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if (rises_a >= 17) reached = 1'b1;
      else @(negedge clk);
    end
    check_eq("t3_bit17", {31'd0, reached}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t3_csn",   {31'd0, bus_a.cs_n}, 32'd1);
    check_eq("t3_sclk",  {31'd0, bus_a.sclk}, 32'd0);
    check_eq("t3_data",  data_a, 32'h0);
    check_eq("t3_valid", {31'd0, valid_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    left_idle = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (valid_a !== 1'b0) saw_valid = 1'b1;
      if (nb_a !== 1'b1) left_idle = 1'b1;
    end
    check_eq("t3_no_valid", {31'd0, saw_valid}, 32'd0);
    check_eq("t3_idle",     {31'd0, left_idle}, 32'd0);
    run_single(0, 32'h0F0F_0F0F, 32'h0, 264, "t3b");

    // CLK_DIV=3 instance
    run_single(1, 32'h0001_0004, 32'h0, 198, "t4");

    // Reader handshake: raise ena while idle, drop once busy, await data
    next_a = 32'h3E80_1F40;
    @(negedge clk);
    ena_a  = 1'b1;
    t_prev = cyc;
    waited = 0;
    while (nb_a !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    ena_a  = 1'b0;
    check_eq("t5_accept", {31'd0, nb_a}, 32'd0);
    waited = 0;
    while (valid_a !== 1'b1 && waited < 24000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("t5_valid", {31'd0, valid_a}, 32'd1);
    check_eq("t5_data", data_a, 32'h3E80_1F40);
    check_eq("t5_latency", cyc - t_prev, 265);
    $display("txn t5: inst 0 data 0x%08h after %0d cycles", data_a, cyc - t_prev);
    repeat (5) @(negedge clk);

    // sclk behaviour over the whole run
    check_eq("a_sclk_while_deselected", viol_a, 0);
    check_eq("b_sclk_while_deselected", viol_b, 0);
    check_eq("a_windows_not_32", winbad_a, 0);
    check_eq("b_windows_not_32", winbad_b, 0);
    check_eq("a_windows", win_a, 6);
    check_eq("b_windows", win_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
